// File: rtl/deserializer.sv
// Serial-to-parallel receiver: gathers each valid burst MSB first into a
// left-aligned word and reports its bit count; runt bursts are flagged.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              deser_err_o
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t state, state_n;

  logic [MOD_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] word, word_n;
  logic [DATA_W-1:0] full;
  logic [MOD_W-1:0]  idx;
  logic              last;
  logic              long_enough;

  logic [DATA_W-1:0] data_n;
  logic [MOD_W-1:0]  mod_n;
  logic              val_n;
  logic              err_n;

  assign idx         = MOD_W'(DATA_W - 1) - cnt;
  assign last        = 32'(cnt) == DATA_W - 1;
  assign long_enough = 32'(cnt) >= MIN_LEN;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      word             <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      deser_err_o      <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      word             <= word_n;
      deser_data_o     <= data_n;
      deser_data_mod_o <= mod_n;
      deser_data_val_o <= val_n;
      deser_err_o      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    data_n  = deser_data_o;
    mod_n   = deser_data_mod_o;
    val_n   = 1'b0;
    err_n   = 1'b0;
    full      = word;
    full[idx] = ser_data_i;

    unique case (state)
      IDLE: begin
        if (ser_data_val_i) begin
          word_n           = '0;
          word_n[DATA_W-1] = ser_data_i;
          cnt_n            = MOD_W'(1);
          state_n          = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          if (last) begin
            // full word: count wraps to 0, which is also the mod encoding
            data_n  = full;
            mod_n   = '0;
            val_n   = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            word_n = full;
            cnt_n  = cnt + MOD_W'(1);
          end
        end else begin
          if (long_enough) begin
            data_n = word;
            mod_n  = cnt;
            val_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus queues expected events,
// a negedge monitor pops and checks each val/err pulse.
module tb_deserializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic              clk;
  logic              srst;
  logic              ser_data;
  logic              ser_val;
  logic [DATA_W-1:0] data;
  logic [MOD_W-1:0]  mod;
  logic              val;
  logic              err;

  typedef struct packed {
    logic              is_err;
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] last_data = '0;
  logic [MOD_W-1:0]  last_mod  = '0;

  deserializer #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W),
    .MIN_LEN(3)
  ) dut (
    .clk_i           (clk),
    .srst_i          (srst),
    .ser_data_i      (ser_data),
    .ser_data_val_i  (ser_val),
    .deser_data_o    (data),
    .deser_data_mod_o(mod),
    .deser_data_val_o(val),
    .deser_err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input logic v, input logic d);
    ser_val  = v;
    ser_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d,
                           input logic [MOD_W-1:0] m);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = d;
    e.mod     = m;
    last_data = d;
    last_mod  = m;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_data;
    e.mod    = last_mod;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] w, input int len);
    for (int i = 0; i < len; i++) tick(1'b1, w[DATA_W-1-i]);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!srst && (val || err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected: val=%0b err=%0b data=%0h mod=%0d",
                 val, err, data, mod);
      end else begin
        e = exp_q.pop_front();
        check("val", 32'(val), 32'(!e.is_err));
        check("err", 32'(err), 32'(e.is_err));
        check("data", 32'(data), 32'(e.data));
        check("mod", 32'(mod), 32'(e.mod));
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] mask;
    int                rm;

    srst     = 1'b1;
    ser_val  = 1'b0;
    ser_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 0);
    check("rst_mod", 32'(mod), 0);
    check("rst_val", 32'(val), 0);
    check("rst_err", 32'(err), 0);
    srst = 1'b0;
    tick(1'b0, 1'b0);

    // 5-bit burst 10110
    push_word(16'hB000, 4'd5);
    send_bits(16'hB000, 5);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // full word then 4-bit burst with no gap
    push_word(16'hA5C3, 4'd0);
    push_word(16'hF000, 4'd4);
    send_bits(16'hA5C3, 16);
    send_bits(16'hF000, 4);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // runts of length 1 and 2, then a legal length-3 burst
    push_err();
    send_bits(16'h8000, 1);
    tick(1'b0, 1'b1);
    push_err();
    send_bits(16'h8000, 2);
    tick(1'b0, 1'b0);
    push_word(16'hC000, 4'd3);
    send_bits(16'hC000, 3);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // full word followed by val low: exactly one emit
    push_word(16'h1234, 4'd0);
    send_bits(16'h1234, 16);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // reset mid-burst; srst overrides val
    send_bits(16'hFE00, 7);
    srst = 1'b1;
    tick(1'b1, 1'b1);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_mod", 32'(mod), 0);
    check("mid_rst_val", 32'(val), 0);
    check("mid_rst_err", 32'(err), 0);
    tick(1'b0, 1'b0);
    srst      = 1'b0;
    last_data = '0;
    last_mod  = '0;
    push_word(16'h5000, 4'd4);
    send_bits(16'h5000, 4);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // serializer-style random words, one gap cycle between bursts
    for (int n = 0; n < 200; n++) begin
      rd   = DATA_W'($urandom);
      rm   = $urandom_range(15, 3);
      mask = 16'hFFFF >> rm;
      push_word(rd & ~mask, MOD_W'(rm));
      send_bits(rd, rm);
      tick(1'b0, 1'b1);
    end

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
